// File: rtl/pack_mode_controller.sv
// Battery pack operating-mode FSM: precharge, charge/discharge, all-off dwell and latched fault.
// Optional `SOC_HYST_EN adds a hysteresis band to the IDLE entry thresholds.
module pack_mode_controller #(
    parameter logic [7:0] SOC_CHG_STOP  = 8'd100,
    parameter logic [7:0] SOC_DSG_STOP  = 8'd5,
    parameter logic [7:0] SOC_HYST      = 8'd3,
    parameter logic [7:0] PRECHG_CYCLES = 8'd16,
    parameter logic [7:0] DWELL_CYCLES  = 8'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       charge_req,
    input  logic       discharge_req,
    input  logic [7:0] soc_percent,
    input  logic       fault_in,
    input  logic       fault_clr,
    output logic       charge_en_fsm,
    output logic       discharge_en_fsm,
    output logic       precharge_en,
    output logic       fault_latched,
    output logic [2:0] state_o
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned THR_W = 9;

`ifdef SOC_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // Entry thresholds are one bit wider so the hysteresis sum cannot overflow.
    localparam logic [7:0]       HYST      = HYST_ON ? SOC_HYST : 8'd0;
    localparam logic [THR_W-1:0] CHG_ENTRY = (HYST > SOC_CHG_STOP) ? THR_W'(0)
                                           : THR_W'(SOC_CHG_STOP) - THR_W'(HYST);
    localparam logic [THR_W-1:0] DSG_ENTRY = THR_W'(SOC_DSG_STOP) + THR_W'(HYST);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRECHG = 3'd1,
        S_CHARGE = 3'd2,
        S_DISCHG = 3'd3,
        S_DWELL  = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_dsg_q, tgt_dsg_d;
    logic             chg_en_q, dsg_en_q, pre_en_q, flt_q;

    logic             chg_entry_ok_c;
    logic             dsg_entry_ok_c;
    logic             prechg_abort_c;
    logic [CNT_W-1:0] cnt_inc_c;

    assign chg_entry_ok_c = {1'b0, soc_percent} < CHG_ENTRY;
    assign dsg_entry_ok_c = {1'b0, soc_percent} > DSG_ENTRY;
    assign prechg_abort_c = tgt_dsg_q ? (!discharge_req || charge_req)
                                      : (!charge_req || discharge_req);
    assign cnt_inc_c      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state logic; fault_in overrides every other transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_dsg_d = tgt_dsg_q;
        if (fault_in) begin
            state_d   = S_FAULT;
            cnt_d     = '0;
            tgt_dsg_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (charge_req && !discharge_req && chg_entry_ok_c) begin
                        state_d   = S_PRECHG;
                        cnt_d     = CNT_W'(1);
                        tgt_dsg_d = 1'b0;
                    end else if (discharge_req && !charge_req && dsg_entry_ok_c) begin
                        state_d   = S_PRECHG;
                        cnt_d     = CNT_W'(1);
                        tgt_dsg_d = 1'b1;
                    end
                end
                S_PRECHG: begin
                    if (prechg_abort_c) begin
                        state_d   = S_DWELL;
                        cnt_d     = CNT_W'(1);
                        tgt_dsg_d = 1'b0;
                    end else if (cnt_q >= PRECHG_CYCLES) begin
                        state_d   = tgt_dsg_q ? S_DISCHG : S_CHARGE;
                        cnt_d     = '0;
                        tgt_dsg_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_CHARGE: begin
                    if (!charge_req || discharge_req || soc_percent >= SOC_CHG_STOP) begin
                        state_d = S_DWELL;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_DISCHG: begin
                    if (!discharge_req || charge_req || soc_percent <= SOC_DSG_STOP) begin
                        state_d = S_DWELL;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_DWELL: begin
                    if (cnt_q >= DWELL_CYCLES) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        state_d = S_DWELL;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d   = S_FAULT;
                    cnt_d     = '0;
                    tgt_dsg_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with state_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tgt_dsg_q <= 1'b0;
            chg_en_q  <= 1'b0;
            dsg_en_q  <= 1'b0;
            pre_en_q  <= 1'b0;
            flt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_dsg_q <= tgt_dsg_d;
            chg_en_q  <= (state_d == S_CHARGE);
            dsg_en_q  <= (state_d == S_DISCHG);
            pre_en_q  <= (state_d == S_PRECHG);
            flt_q     <= (state_d == S_FAULT);
        end
    end

    assign charge_en_fsm    = chg_en_q;
    assign discharge_en_fsm = dsg_en_q;
    assign precharge_en     = pre_en_q;
    assign fault_latched    = flt_q;
    assign state_o          = state_q;

endmodule
